// File: rtl/bf8b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf8b_pkg
// Description : Shared constants and types for the byte-wide fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package bf8b_pkg;

    localparam int DEF_M_WIDTH    = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_INST_WIDTH = 32;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_INTEGER = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Assembles one instruction from consecutive byte reads and
//               hands it to the decoder with a single-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import bf8b_pkg::*;
#(
    parameter int M_WIDTH    = DEF_M_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [M_WIDTH-1:0]    mem_data,
    input  logic                  mem_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic                  busy,
    output logic                  fault
);

    localparam int INST_BYTES = INST_WIDTH / M_WIDTH;
    localparam int CNT_W      = $clog2(INST_BYTES);

    fetch_state_t          r_state;
    fetch_state_t          w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_W-1:0]      r_cnt;
    logic [INST_WIDTH-1:0] r_buf;
    logic [INST_WIDTH-1:0] r_inst;
    logic [INST_WIDTH-1:0] w_word;
    logic                  r_fault;
    logic                  w_aligned;
    logic                  w_last;

    assign w_aligned = (pc[CNT_W-1:0] == '0);
    assign w_last    = (r_cnt == CNT_W'(INST_BYTES - 1));
    assign inst      = r_inst;
    assign fault     = r_fault;

    // Buffer with the current beat merged in; the final beat's word goes
    // straight to inst so it is valid in the same cycle as inst_valid.
    always_comb begin
        w_word = r_buf;
        w_word[M_WIDTH*r_cnt +: M_WIDTH] = mem_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        inst_valid = 1'b0;
        busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && w_aligned) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                mem_rd   = 1'b1;
                busy     = 1'b1;
                mem_addr = r_base + ADDR_WIDTH'(r_cnt);
                if (mem_valid && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                inst_valid = 1'b1;
                busy       = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (flush) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base  <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_inst  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_fault <= (r_state == IDLE) && start && !w_aligned && !flush;
            if (!flush) begin
                if (r_state == IDLE && start && w_aligned) begin
                    r_base <= pc;
                    r_cnt  <= '0;
                end else if (r_state == FETCH && mem_valid) begin
                    r_buf <= w_word;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_inst <= w_word;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Directed and randomized checks of inst_fetch against a
//               transaction-level model of the byte fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pc = '0;
    logic        flush = 1'b0;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data = '0;
    logic        mem_valid = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        busy;
    logic        fault;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // transaction-level model
    bit          m_active;
    bit          m_done;
    bit          m_fault;
    int          m_base;
    int          m_cnt;
    int          m_bytes[4];
    logic [31:0] m_inst;

    inst_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pc        (pc),
        .flush     (flush),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .inst      (inst),
        .inst_valid(inst_valid),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %08h want %08h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_done   = 0;
        m_fault  = 0;
        m_base   = 0;
        m_cnt    = 0;
        m_inst   = '0;
        foreach (m_bytes[i]) m_bytes[i] = 0;
    endtask

    task automatic model_step();
        bit n_fault;
        n_fault = !m_active && !m_done && start && (pc % 4 != 0) && !flush;
        if (flush) begin
            m_active = 0;
            m_done   = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (mem_valid) begin
                m_bytes[m_cnt] = int'(mem_data);
                m_cnt++;
                if (m_cnt == 4) begin
                    m_inst   = 32'(m_bytes[0] + m_bytes[1] * 256 + m_bytes[2] * 65536
                                   + m_bytes[3] * 16777216);
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else if (start && (pc % 4 == 0)) begin
            m_active = 1;
            m_base   = int'(pc);
            m_cnt    = 0;
        end
        m_fault = n_fault;
    endtask

    task automatic compare();
        chk("mem_rd", 32'(mem_rd), 32'(m_active));
        chk("mem_addr", 32'(mem_addr), m_active ? 32'((m_base + m_cnt) % 256) : 32'd0);
        chk("busy", 32'(busy), 32'(m_active | m_done));
        chk("inst_valid", 32'(inst_valid), 32'(m_done));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("inst", inst, m_inst);
    endtask

    task automatic tick(input logic s, input logic [7:0] p, input logic f,
                        input logic v, input logic [7:0] d);
        start     = s;
        pc        = p;
        flush     = f;
        mem_valid = v;
        mem_data  = d;
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic fetch4(input logic [7:0] p, input logic [31:0] w);
        tick(1'b1, p, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("fetch_addr", 32'(mem_addr), 32'(8'(p + 8'(i))));
            tick(1'b0, 8'h00, 1'b0, 1'b1, w[8*i +: 8]);
        end
        chk("fetch_valid", 32'(inst_valid), 32'd1);
        chk("fetch_inst", inst, w);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        chk("reset_inst", inst, 32'h0);
        rst = 1'b0;

        // zero-wait fetch: instruction appears in cycle 5
        cyc = 0;
        tick(1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
        chk("zw_addr0", 32'(mem_addr), 32'h10);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h93);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h50);
        chk("zw_addr3", 32'(mem_addr), 32'h13);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        chk("zw_cycle", 32'(cyc), 32'd5);
        chk("zw_valid", 32'(inst_valid), 32'd1);
        chk("zw_inst", inst, 32'h00500093);
        tick(1'b1, 8'h40, 1'b0, 1'b0, 8'h00);
        chk("done_ignores_start", 32'(busy), 32'd0);

        // wait states before beat 2
        cyc = 0;
        tick(1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'hB7);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h10);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 8'hEE);
        chk("ws_addr", 32'(mem_addr), 32'h12);
        chk("ws_rd", 32'(mem_rd), 32'd1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 8'hEE);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        chk("ws_valid_early", 32'(inst_valid), 32'd0);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        chk("ws_cycle", 32'(cyc), 32'd7);
        chk("ws_valid", 32'(inst_valid), 32'd1);
        chk("ws_inst", inst, 32'h000010B7);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // address wrap, then fetch from 0
        fetch4(8'hFC, 32'h0000_0013);
        fetch4(8'h00, 32'hDEAD_BEEF);

        // misaligned pc
        tick(1'b1, 8'h12, 1'b0, 1'b0, 8'h00);
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_rd", 32'(mem_rd), 32'd0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("mis_pulse", 32'(fault), 32'd0);
        chk("mis_inst", inst, 32'hDEAD_BEEF);

        // flush on beat 2 together with mem_valid
        tick(1'b1, 8'h40, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h11);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h22);
        tick(1'b1, 8'h80, 1'b1, 1'b1, 8'h33);
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_rd", 32'(mem_rd), 32'd0);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h44);
        chk("fl_novalid", 32'(inst_valid), 32'd0);
        chk("fl_inst", inst, 32'hDEAD_BEEF);
        fetch4(8'h44, 32'h0010_0093);

        // asynchronous reset mid-fetch
        tick(1'b1, 8'h08, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 8'h55);
        rst = 1'b1;
        model_reset();
        start = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_inst", inst, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fetch4(8'h20, 32'h0000_0113);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic       s, f, v;
            logic [7:0] p;
            s = ($urandom_range(0, 3) == 0);
            p = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
            f = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 1) == 1);
            tick(s, p, f, v, 8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
